// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-buffer entry type
// used by the instruction-fetch stage.
package fetch_pkg;

    localparam int          XLEN        = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer of fetched entries with
// synchronous push/pop/flush; flush wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    output T              head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A pop frees the slot in the same edge, so push-at-full is legal.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-based issue to a 1-cycle imem, epoch tagging
// for redirects; FETCH_PERF_EN adds pop/stall counters.
module fetch_unit #(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    import fetch_pkg::*;

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] ifl_pc_q;
    logic [XLEN-1:0] ifl_pc_d;
    logic            ifl_q;
    logic            ifl_d;
    logic            ifl_ep_q;
    logic            ifl_ep_d;
    logic            epoch_q;
    logic            epoch_d;

    logic [XLEN-1:0] redir_addr;
    logic            pop;
    logic            push;
    logic            credit_ok;
    logic [CW:0]     occ;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    entry_t          push_entry;
    entry_t          head;

    assign redir_addr = {redirect_pc[XLEN-1:2], 2'b00};

    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

    // Slots left after this cycle's pop must cover the in-flight word too.
    assign occ = {1'b0, count}
               - {{CW{1'b0}}, pop}
               + {{CW{1'b0}}, ifl_q};
    assign credit_ok = (occ < DEPTH_W);

    assign imem_req_valid = reset && (redirect_valid || credit_ok);
    assign imem_req_addr  = redirect_valid ? redir_addr : pc_q;

    assign push             = ifl_q && (ifl_ep_q == epoch_q);
    assign push_entry.instr = imem_rsp_data;
    assign push_entry.pc    = ifl_pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ifl_q    <= 1'b0;
            ifl_pc_q <= '0;
            ifl_ep_q <= 1'b0;
            epoch_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ifl_q    <= ifl_d;
            ifl_pc_q <= ifl_pc_d;
            ifl_ep_q <= ifl_ep_d;
            epoch_q  <= epoch_d;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        epoch_d  = epoch_q;
        ifl_d    = imem_req_valid;
        ifl_pc_d = imem_req_addr;
        if (redirect_valid) begin
            epoch_d = ~epoch_q;
            pc_d    = redir_addr + STEP;
        end else if (imem_req_valid) begin
            pc_d = pc_q + STEP;
        end
        ifl_ep_d = epoch_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!reset)
        (push && full && !redirect_valid) |-> pop
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    // A redirect cycle delivers nothing to decode, so it is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else if (!redirect_valid) begin
            if (pop)                         fetched_q <= fetched_q + 32'd1;
            if (instr_valid && !instr_ready) stall_q   <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a 1-cycle
// instruction memory holding word[i] = i.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_pc;
    int          reqs;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word[i] = i; junk when no request so stray captures show up
    always @(posedge clk) begin
        if (imem_req_valid) imem_rsp_data <= {2'b00, imem_req_addr[31:2]};
        else                imem_rsp_data <= 32'hDEAD_BEEF;
    end

    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b want 0", imem_req_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", instr_pc); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL c0_req got %0b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL c0_addr got %h want 0", imem_req_addr); end
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL c1_valid got %0b want 0", instr_valid); end
        @(negedge clk);
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid got %0b want 1", instr_valid); end
            n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc got %h want %h", instr_pc, exp_pc); end
            n_cmp++; if (instr !== (exp_pc >> 2)) begin n_err++; $display("FAIL stream_instr got %h want %h", instr, exp_pc >> 2); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req_valid) reqs++;
            @(negedge clk);
        end
        n_cmp++; if (reqs !== 2) begin n_err++; $display("FAIL stall_reqs got %0d want 2", reqs); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req got %0b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got %0b want 1", instr_valid); end
        n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL stall_head got %h want %h", instr_pc, exp_pc); end
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL resume_valid got %0b want 1", instr_valid); end
            n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL resume_pc got %h want %h", instr_pc, exp_pc); end
            n_cmp++; if (instr !== (exp_pc >> 2)) begin n_err++; $display("FAIL resume_instr got %h want %h", instr, exp_pc >> 2); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL redir_req got %0b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", imem_req_addr); end
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble got %0b want 0", instr_valid); end
        @(negedge clk);
        exp_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid got %0b want 1", instr_valid); end
            n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL redir_pc got %h want %h", instr_pc, exp_pc); end
            n_cmp++; if (instr !== (exp_pc >> 2)) begin n_err++; $display("FAIL redir_instr got %h want %h", instr, exp_pc >> 2); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_pc = 32'h300;
        #1;
        n_cmp++; if (imem_req_addr !== 32'h300) begin n_err++; $display("FAIL b2b_addr got %h want 300", imem_req_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL b2b_flush got %0b want 0", instr_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got %0b want 0", instr_valid); end
        @(negedge clk);
        n_cmp++; if (instr_pc !== 32'h300) begin n_err++; $display("FAIL b2b_pc0 got %h want 300", instr_pc); end
        n_cmp++; if (instr !== 32'hC0) begin n_err++; $display("FAIL b2b_instr0 got %h want c0", instr); end
        @(negedge clk);
        n_cmp++; if (instr_pc !== 32'h304) begin n_err++; $display("FAIL b2b_pc1 got %h want 304", instr_pc); end
    endtask

    task automatic test_unaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        n_cmp++; if (imem_req_addr !== 32'h200) begin n_err++; $display("FAIL unal_addr got %h want 200", imem_req_addr); end
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL unal_bubble got %0b want 0", instr_valid); end
        @(negedge clk);
        n_cmp++; if (instr_pc !== 32'h200) begin n_err++; $display("FAIL unal_pc0 got %h want 200", instr_pc); end
        n_cmp++; if (instr !== 32'h80) begin n_err++; $display("FAIL unal_instr0 got %h want 80", instr); end
        @(negedge clk);
        n_cmp++; if (instr_pc !== 32'h204) begin n_err++; $display("FAIL unal_pc1 got %h want 204", instr_pc); end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got %0b want 1", instr_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %0b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_req got %0b want 0", imem_req_valid); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL mid_pc got %h want 0", instr_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL mid_addr got %h want 0", imem_req_addr); end
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_c1 got %0b want 0", instr_valid); end
        @(negedge clk);
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL mid_pc0 got %h want 0", instr_pc); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL mid_instr0 got %h want 0", instr); end
        @(negedge clk);
        n_cmp++; if (instr_pc !== 32'h4) begin n_err++; $display("FAIL mid_pc1 got %h want 4", instr_pc); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (perf_fetched !== 32'd0) begin n_err++; $display("FAIL perf_rst_f got %0d want 0", perf_fetched); end
        n_cmp++; if (perf_stall !== 32'd0) begin n_err++; $display("FAIL perf_rst_s got %0d want 0", perf_stall); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        repeat (5) @(negedge clk);
        instr_ready = 1'b1;
        repeat (8) @(negedge clk);
        instr_ready = 1'b0;
        n_cmp++; if (perf_fetched !== 32'd8) begin n_err++; $display("FAIL perf_fetched got %0d want 8", perf_fetched); end
        n_cmp++; if (perf_stall !== 32'd5) begin n_err++; $display("FAIL perf_stall got %0d want 5", perf_stall); end
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (perf_fetched !== 32'd8) begin n_err++; $display("FAIL perf_redir_f got %0d want 8", perf_fetched); end
        n_cmp++; if (perf_stall !== 32'd5) begin n_err++; $display("FAIL perf_redir_s got %0d want 5", perf_stall); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_unaligned();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
